// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if: CPU-side and memory-side bus bundle around the OAM DMA controller
interface oam_dma_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_wr_en;
   logic                  cpu_rd_en;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  dma_busy;
   modport master (
      input  cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, mem_rdata,
      output cpu_rdata, mem_addr, mem_wdata, mem_wr_en, mem_rd_en, dma_busy
   );
   modport slave (
      output cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, mem_rdata,
      input  cpu_rdata, mem_addr, mem_wdata, mem_wr_en, mem_rd_en, dma_busy
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: muxes the CPU bus and a page-to-OAM DMA engine onto the single memory port
module oam_dma_ctrl #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    DATA_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [ADDR_WIDTH-1:0] OAM_BASE     = 16'hFE00,
   parameter int                    XFER_LEN     = 160,
   parameter logic [ADDR_WIDTH-1:0] HRAM_BASE    = 16'hFF80
) (
   input  logic           clk,
   input  logic           rst,
   oam_dma_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
   state_t     state, state_nxt;
   logic [7:0] src_hi, idx, byte_buf, page;
   logic       reg_wr, reg_rd, last, busy;
   // The register must not be shadowed by the external HRAM path while busy
   if (DMA_REG_ADDR >= HRAM_BASE) begin : g_reg_check
      $error("DMA register must sit below HRAM_BASE");
   end
   assign reg_wr = bus.cpu_wr_en && bus.cpu_addr == DMA_REG_ADDR;
   assign reg_rd = bus.cpu_rd_en && bus.cpu_addr == DMA_REG_ADDR;
   assign last   = idx == 8'(XFER_LEN - 1);
   assign page   = src_hi <= 8'hDF ? src_hi : src_hi & 8'hDF;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         src_hi   <= 8'h00;
         idx      <= 8'h00;
         byte_buf <= 8'h00;
      end else begin
         state <= state_nxt;
         if (state == READ) byte_buf <= 8'(bus.mem_rdata);
         if (reg_wr) begin
            src_hi <= 8'(bus.cpu_wdata);
            idx    <= 8'h00;
         end else if (state == WRITE) idx <= last ? 8'h00 : idx + 8'h01;
      end
   end
   always_comb begin
      state_nxt = reg_wr ? START : state == START ? READ : state == READ ? WRITE :
                  (state == WRITE && !last) ? READ : IDLE;
   end
   // Outputs are forced to their reset values while rst is held so an aborted copy writes nothing more
   always_comb begin
      busy          = state != IDLE;
      bus.dma_busy  = !rst && busy;
      bus.mem_addr  = rst ? '0 : state == READ ? ADDR_WIDTH'({page, idx}) :
                      state == WRITE ? OAM_BASE + ADDR_WIDTH'(idx) : busy ? '0 : bus.cpu_addr;
      bus.mem_wdata = rst ? '0 : state == WRITE ? DATA_WIDTH'(byte_buf) : busy ? '0 : bus.cpu_wdata;
      bus.mem_rd_en = !rst && (state == READ || (!busy && bus.cpu_rd_en));
      bus.mem_wr_en = !rst && (state == WRITE || (!busy && bus.cpu_wr_en && !reg_wr));
      bus.cpu_rdata = rst ? '0 : reg_rd ? DATA_WIDTH'(src_hi) : busy ? '1 : bus.mem_rdata;
   end
endmodule
